// File: rtl/instr_deserializer_pkg.sv
// Shared definitions for the instruction deserializer and the request queue.
//   - default field widths and the derived frame/instruction widths
//   - opcode bit that routes an instruction to the SHA side
//   - receive FSM state encoding
//   - clog2 and frame_width helpers usable in constant expressions
package instr_deserializer_pkg;

  localparam int ADDRW_DEF   = 24;
  localparam int OPCODEW_DEF = 2;

  // Number of bits needed to hold values 0 .. value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int frame_width(input int addrw, input int opcodew);
    return 3 * addrw + opcodew;
  endfunction

  localparam int FRAMEW = frame_width(ADDRW_DEF, OPCODEW_DEF);
  localparam int INSTRW = FRAMEW;

  // opcode[OPC_SHA_BIT] = 0 -> AES queue, 1 -> SHA queue.
  localparam int OPC_SHA_BIT = 0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    COMPLETE = 2'd2
  } state_t;

endpackage

// File: rtl/instr_deserializer_if.sv
// Instruction hand-off bus between the deserializer and the request queue.
//   opcode, key_addr, text_addr, dest_addr : held instruction fields
//   valid_out : holding register has an instruction not yet accepted
//   ready_aes / ready_sha : queue sides able to accept
// Handshake: a transfer happens on every clk rising edge where valid_out is 1
// and the ready of the side chosen by opcode[OPC_SHA_BIT] is 1. While
// valid_out is 1 and no transfer has happened the fields are held stable;
// valid_out does not depend combinationally on either ready.
interface instr_deserializer_if
  import instr_deserializer_pkg::*;
#(
  parameter int ADDRW   = ADDRW_DEF,
  parameter int OPCODEW = OPCODEW_DEF
);
  logic [OPCODEW-1:0] opcode;
  logic [ADDRW-1:0]   key_addr;
  logic [ADDRW-1:0]   text_addr;
  logic [ADDRW-1:0]   dest_addr;
  logic               valid_out;
  logic               ready_aes;
  logic               ready_sha;

  modport master (
    output opcode, key_addr, text_addr, dest_addr, valid_out,
    input  ready_aes, ready_sha
  );

  modport slave (
    input  opcode, key_addr, text_addr, dest_addr, valid_out,
    output ready_aes, ready_sha
  );
endinterface

// File: rtl/instr_deserializer_sync_edge.sv
// sync_edge: brings one asynchronous input into the clk domain.
//   clk, rst_n : clock, asynchronous active-low reset
//   d          : asynchronous input
//   q          : synchronized level (STAGES flops)
//   rise       : high for one clk when q goes 0 -> 1
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise
);
  logic [STAGES-1:0] pipe;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe <= '0;
      prev <= 1'b0;
    end else begin
      pipe <= {pipe[STAGES-2:0], d};
      prev <= pipe[STAGES-1];
    end
  end

  assign q    = pipe[STAGES-1];
  assign rise = pipe[STAGES-1] & ~prev;
endmodule

// File: rtl/instr_deserializer.sv
// instr_deserializer: receives one instruction per SPI mode-0 frame (MSB
// first, bits {opcode, key, text, dest}) and presents it on a single holding
// register with a valid/ready handshake routed by opcode[OPC_SHA_BIT].
//   clk, rst_n                   : clock, asynchronous active-low reset
//   spi_sclk, spi_cs_n, spi_mosi : host link, asynchronous to clk
//   q (master)                   : held instruction, valid_out, ready_aes/sha
//   busy                         : equals valid_out
//   err_drop                     : one-clk pulse when a complete frame is dropped
//   state_dbg                    : current receive FSM state
module instr_deserializer
  import instr_deserializer_pkg::*;
#(
  parameter int ADDRW       = 24,
  parameter int OPCODEW     = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  instr_deserializer_if.master  q,
  output logic                  busy,
  output logic                  err_drop,
  output state_t                state_dbg
);
  localparam int FW   = frame_width(ADDRW, OPCODEW);
  localparam int CNTW = clog2(FW + 1);

  logic sclk_s, sclk_rise, cs_s, cs_rise, mosi_s, mosi_rise;
  logic unused_rises;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(spi_sclk), .q(sclk_s), .rise(sclk_rise)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(spi_cs_n), .q(cs_s), .rise(cs_rise)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(spi_mosi), .q(mosi_s), .rise(mosi_rise)
  );
  assign unused_rises = &{1'b0, sclk_s, cs_rise, mosi_rise};

  state_t            state, state_nxt;
  logic [CNTW-1:0]   cnt;
  logic [FW-2:0]     shreg;     // last bit goes straight into the holding register
  logic              armed;     // cs_n has been seen high since reset
  logic              cnt_clr, shift_en, last_bit;
  logic [FW-1:0]     frame_in;

  logic [OPCODEW-1:0] opc_r;
  logic [ADDRW-1:0]   key_r, text_r, dest_r;
  logic               valid_r;
  logic               sel_ready, xfer, load;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (armed && !cs_s) state_nxt = SHIFT;
      SHIFT:    if (cs_s)           state_nxt = IDLE;
                else if (last_bit)  state_nxt = COMPLETE;
      COMPLETE: if (cs_s)           state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // FSM outputs; an sclk rise in the same cycle that cs_n is seen high is
  // treated as part of the abort, not as a data bit.
  always_comb begin
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    last_bit = 1'b0;
    case (state)
      IDLE:  cnt_clr = armed && !cs_s;
      SHIFT: begin
        shift_en = !cs_s && sclk_rise;
        last_bit = !cs_s && sclk_rise && (cnt == CNTW'(FW - 1));
      end
      default: ;
    endcase
  end

  assign state_dbg = state;

  // After reset the synced cs_n reads 0; a frame may start only once cs_n
  // has actually been observed high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    armed <= 1'b0;
    else if (cs_s) armed <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (cnt_clr) begin
      cnt   <= '0;
    end else if (shift_en) begin
      cnt   <= cnt + CNTW'(1);
      shreg <= {shreg[FW-3:0], mosi_s};
    end
  end

  assign frame_in  = {shreg, mosi_s};
  assign sel_ready = opc_r[OPC_SHA_BIT] ? q.ready_sha : q.ready_aes;
  assign xfer      = valid_r && sel_ready;
  // A frame completing while the held one leaves on the same edge still loads.
  assign load      = last_bit && (!valid_r || xfer);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opc_r    <= '0;
      key_r    <= '0;
      text_r   <= '0;
      dest_r   <= '0;
      valid_r  <= 1'b0;
      err_drop <= 1'b0;
    end else begin
      err_drop <= last_bit && !load;
      if (load) begin
        opc_r   <= frame_in[FW-1 -: OPCODEW];
        key_r   <= frame_in[3*ADDRW-1 -: ADDRW];
        text_r  <= frame_in[2*ADDRW-1 -: ADDRW];
        dest_r  <= frame_in[ADDRW-1:0];
        valid_r <= 1'b1;
      end else if (xfer) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign q.opcode    = opc_r;
  assign q.key_addr  = key_r;
  assign q.text_addr = text_r;
  assign q.dest_addr = dest_r;
  assign q.valid_out = valid_r;
  assign busy        = valid_r;
endmodule

// File: doc/instr_deserializer.md
Name: instr_deserializer

Overview:
- Upstream stage of the request queue. Receives one instruction per frame from the host CPU over a 3-wire SPI-style link (mode 0, MSB first).
- Synchronizes the link into the clk domain and assembles opcode, key_addr, text_addr and dest_addr.
- Presents each assembled instruction with a valid/ready handshake, routed by opcode[0] to the matching queue side: 0 = AES, 1 = SHA.
- Single holding register. Exposes busy to the host and flags frames it had to drop.

Parameters:
- ADDRW, 24, width of each address field
- OPCODEW, 2, opcode width
- SYNC_STAGES, 2, flip-flop stages per synchronized input (minimum 2)

Ports:
- clk  input  1  system clock; must run at least 4x spi_sclk
- rst_n  input  1  reset
- spi_sclk  input  1  host serial clock, asynchronous to clk
- spi_cs_n  input  1  frame select, active low, asynchronous
- spi_mosi  input  1  serial data, asynchronous
- ready_aes  input  1  AES queue can accept an instruction
- ready_sha  input  1  SHA queue can accept an instruction
- opcode  output  OPCODEW  held opcode
- key_addr  output  ADDRW  held key address
- text_addr  output  ADDRW  held text address
- dest_addr  output  ADDRW  held destination address
- valid_out  output  1  holding register contains an instruction not yet accepted
- busy  output  1  to host: equals valid_out
- err_drop  output  1  one-cycle pulse when a complete frame is discarded

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. Every output resets to 0, as do all synchronizers, the shift register, the bit counter and the FSM (state IDLE).
- Frame width: FRAMEW = 3*ADDRW + OPCODEW (74 at defaults).
- Bit order: opcode MSB first, then key_addr, text_addr, dest_addr, each MSB first. The assembled bits are {opcode, key, text, dest}, matching the queue's instruction packing.
- Synchronization: spi_sclk, spi_cs_n and spi_mosi each pass through SYNC_STAGES flops.
- Edge detection: an sclk rise is a synced sclk of 1 whose previous synced value was 0. mosi is sampled on that cycle.
- Receive FSM:
  - IDLE: when synced cs_n = 0, clear the counter and go to SHIFT.
  - SHIFT: on each sclk rise, shift mosi into the LSB and increment the counter (width clog2(FRAMEW+1)). When the FRAMEW-th bit is shifted, go to COMPLETE. If synced cs_n goes to 1 first, abort: discard the partial frame, no err_drop, go to IDLE.
  - COMPLETE: ignore further sclk rises (extra bits are dropped). When synced cs_n = 1, go to IDLE.
- Load: on the cycle after the FRAMEW-th bit is shifted (i.e. entry into COMPLETE):
  - If valid_out = 0, load the holding register and set valid_out = 1. Latency is 1 clk from detecting the final sclk rise.
  - If valid_out = 1 and no handshake occurs that cycle, drop the new frame and pulse err_drop for 1 clk. The held instruction is unchanged.
- Handshake: sel_ready = opcode[0] ? ready_sha : ready_aes. A transfer happens on any posedge where valid_out && sel_ready. valid_out clears the next cycle. Fields stay stable while valid_out = 1.
- Simultaneous transfer and load on the same cycle: load the new frame and keep valid_out = 1. The new frame is not dropped.
- Routing: only opcode[0] selects the target. opcode[1] passes through untouched.
- Reset mid-frame: the partial frame is lost. After rst_n deasserts, a cs_n that is already low is treated as the start of a frame only after it is seen high (the FSM waits in IDLE for cs_n = 1 first).
- busy is combinational from valid_out. No other combinational paths from inputs to outputs.

Decomposition:
- Shared package:
  - FRAMEW and INSTRW localparams
  - opcode bit index constant OPC_SHA_BIT = 0
  - FSM state encodings IDLE, SHIFT, COMPLETE
  - a clog2 function shared with the request queue
- Sub-module: sync_edge, which handles one input with SYNC_STAGES flops and optionally outputs a rise strobe. Instantiate it three times.

Test Plan:
- Send frame opcode=2'b00, key=0x123456, text=0xABCDEF, dest=0x000010 with ready_aes = 1 -> valid_out goes high 1 clk after the last synced edge, fields match exactly, valid_out clears the cycle after the handshake, ready_sha is ignored.
- Send opcode=2'b01 with ready_sha = 0 for 20 clks and ready_aes = 1 -> valid_out and busy stay high and fields stay stable. Raise ready_sha -> transfer occurs and valid_out drops 1 clk later.
- Raise cs_n after 40 bits -> no valid_out and no err_drop. A following full frame (opcode=2'b10, dest=0xFFFFFF) is received correctly.
- Send 80 sclk pulses in one frame -> only the first 74 bits are used and bits 75-80 are ignored.
- Hold frame A unaccepted and complete frame B -> err_drop pulses once and A's fields are retained. Repeat with ready asserted on B's load cycle -> B is loaded and there is no err_drop.
- Assert rst_n low mid-frame with cs_n held low -> all outputs 0. After release, no frame is accepted until cs_n cycles high then low.
